core_inst_seq: RTL and testbench

//  Instruction sequencer for the core: generates the 35-bit inst word consumed by core,
//  so one start pulse runs a full tile. Phases: weight fetch xmem->L0, kernel load, activation

---
 rtl/core_inst_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_seq.sv
// core_inst_seq
//   Instruction sequencer for the core. A single start pulse runs one full tile:
//   weight fetch xmem->L0, kernel load, drain wait, activation fetch xmem->L0,
//   execute, OFIFO drain into pmem, then an optional accumulate/ReLU pass
//   through the SFP. All parameters of the tile are latched on start.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, only accepted while idle
//   w_base       xmem address of the first weight word
//   a_base       xmem address of the first activation word
//   p_base       pmem address of the first psum word
//   len          activation words / psum outputs per tile (0 = no-op)
//   acc_en       run the SFP pass after the OFIFO drain
//   relu_en      drive inst[34] during the SFP pass
//   ofifo_valid  OFIFO in core holds a readable word
//   inst         35-bit instruction word for core (registered)
//   busy         high from start acceptance through the done cycle (registered)
//   done         one-cycle completion pulse (registered)
//
// Timing: the next-state logic computes the word for the current state and the
// output register presents it one cycle later, so inst/busy/done all share the
// same one-cycle lag and no input reaches an output combinationally.
module core_inst_seq #(
    parameter int ROW   = 8,
    parameter int COL   = 8,
    parameter int AW    = 11,
    parameter int LW    = 11,
    parameter int DRAIN = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] p_base,
    input  logic [LW-1:0] len,
    input  logic          acc_en,
    input  logic          relu_en,
    input  logic          ofifo_valid,
    output logic [34:0]   inst,
    output logic          busy,
    output logic          done
);

    // NOP: both SRAMs disabled with write-enable inactive, everything else 0.
    localparam logic [34:0] NOP = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_W_FETCH, S_W_LOAD, S_W_WAIT, S_A_FETCH,
        S_EXEC, S_OF_DRAIN, S_SFP, S_DONE
    } state_t;

    state_t        state, state_d;
    logic [LW-1:0] cnt, cnt_d;        // per-phase step counter / pmem offset
    logic [LW-1:0] rd_cnt, rd_cnt_d;  // OFIFO reads issued during drain
    logic          wr_pend, wr_pend_d; // OFIFO read last cycle -> pmem write now
    logic [AW-1:0] w_q, a_q, p_q;
    logic [LW-1:0] len_q;
    logic          acc_q, relu_q;
    logic [34:0]   inst_d;

    // Instruction fields for the current cycle
    logic          f_relu, f_acc, cen_p, wen_p, cen_x, wen_x;
    logic          f_ofifo_rd, f_l0_rd, f_l0_wr, f_exec, f_load;
    logic [AW-1:0] a_p, a_x;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rd_cnt_d   = rd_cnt;
        wr_pend_d  = 1'b0;
        f_relu     = 1'b0;
        f_acc      = 1'b0;
        cen_p      = 1'b1;
        wen_p      = 1'b1;
        a_p        = '0;
        cen_x      = 1'b1;
        wen_x      = 1'b1;
        a_x        = '0;
        f_ofifo_rd = 1'b0;
        f_l0_rd    = 1'b0;
        f_l0_wr    = 1'b0;
        f_exec     = 1'b0;
        f_load     = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = (len != '0) ? S_W_FETCH : S_DONE;
            end
            // ROW reads plus one trailing cycle for the last L0 write
            S_W_FETCH: begin
                if (cnt != LW'(ROW)) begin
                    cen_x = 1'b0;
                    a_x   = w_q + AW'(cnt);
                end
                if (cnt != '0) f_l0_wr = 1'b1;
                if (cnt == LW'(ROW)) begin
                    state_d = S_W_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            S_W_LOAD: begin
                f_l0_rd = 1'b1;
                f_load  = 1'b1;
                if (cnt == LW'(COL - 1)) begin
                    state_d = S_W_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            S_W_WAIT: begin
                if (cnt == LW'(DRAIN - 1)) begin
                    state_d = S_A_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            S_A_FETCH: begin
                if (cnt != len_q) begin
                    cen_x = 1'b0;
                    a_x   = a_q + AW'(cnt);
                end
                if (cnt != '0) f_l0_wr = 1'b1;
                if (cnt == len_q) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            S_EXEC: begin
                f_l0_rd = 1'b1;
                f_exec  = 1'b1;
                if (cnt == len_q - LW'(1)) begin
                    state_d  = S_OF_DRAIN;
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            // OFIFO read and pmem write are pipelined: a read in one cycle is
            // written the next, and a new read may overlap that write.
            S_OF_DRAIN: begin
                if (wr_pend) begin
                    cen_p = 1'b0;
                    wen_p = 1'b0;
                    a_p   = p_q + AW'(cnt);
                    if (cnt == len_q - LW'(1)) begin
                        state_d = acc_q ? S_SFP : S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + LW'(1);
                    end
                end
                if (rd_cnt != len_q && ofifo_valid) begin
                    f_ofifo_rd = 1'b1;
                    rd_cnt_d   = rd_cnt + LW'(1);
                    wr_pend_d  = 1'b1;
                end
            end
            S_SFP: begin
                cen_p  = 1'b0;
                a_p    = p_q + AW'(cnt);
                f_acc  = 1'b1;
                f_relu = relu_q;
                if (cnt == len_q - LW'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + LW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        inst_d = {f_relu, f_acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                  f_ofifo_rd, 2'b00, f_l0_rd, f_l0_wr, f_exec, f_load};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rd_cnt  <= '0;
            wr_pend <= 1'b0;
            w_q     <= '0;
            a_q     <= '0;
            p_q     <= '0;
            len_q   <= '0;
            acc_q   <= 1'b0;
            relu_q  <= 1'b0;
            inst    <= NOP;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            rd_cnt  <= rd_cnt_d;
            wr_pend <= wr_pend_d;
            inst    <= inst_d;
            busy    <= (state != S_IDLE) || start;
            done    <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                w_q    <= w_base;
                a_q    <= a_base;
                p_q    <= p_base;
                len_q  <= len;
                acc_q  <= acc_en;
                relu_q <= relu_en;
            end
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// Testbench for core_inst_seq: directed tiles plus randomized tiles, each run's
// instruction trace (one word per busy cycle) compared against a trace built
// from the phase rules of the sequencer.
module tb_core_inst_seq;
    localparam int ROW = 8, COL = 8, DRAIN = 16;
    localparam logic [34:0] NOP = 35'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, acc_en, relu_en, ofifo_valid;
    logic [10:0] w_base, a_base, p_base, len;
    logic [34:0] inst;
    logic        busy, done;

    core_inst_seq dut (
        .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
        .p_base(p_base), .len(len), .acc_en(acc_en), .relu_en(relu_en),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int          vmode = 0;
    logic        v_last = 1'b0;
    logic [34:0] obs_q[$];
    logic        obs_v[$];
    logic [34:0] exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ofifo_valid: 0 = always high, 1 = 1,0,0 repeating, 2 = random
    initial begin
        ofifo_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (vmode)
                0: ofifo_valid = 1'b1;
                1: ofifo_valid = (cyc % 3 == 0);
                default: ofifo_valid = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Each busy word is stored with the ofifo_valid seen by the cycle that produced it.
    initial forever begin
        @(negedge clk);
        if (busy === 1'b1) begin
            obs_q.push_back(inst);
            obs_v.push_back(v_last);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        v_last = ofifo_valid;
    end

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    function automatic logic [34:0] mk(bit relu, bit acc, bit cp, bit wp, logic [10:0] ap,
                                       bit cx, bit wx, logic [10:0] ax, bit ord,
                                       bit l0r, bit l0w, bit ex, bit ld);
        return {relu, acc, cp, wp, ap, cx, wx, ax, ord, 2'b00, l0r, l0w, ex, ld};
    endfunction

    // Expected trace: acceptance NOP, phases, done NOP.
    task automatic build_exp(input logic [10:0] lw, input logic [10:0] la, input logic [10:0] lp,
                             input int ll, input bit lacc, input bit lrelu);
        int k, reads, j, guard;
        bit pend, wr, rd, v;
        exp_q.delete();
        exp_q.push_back(NOP);
        if (ll != 0) begin
            for (int i = 0; i <= ROW; i++)
                exp_q.push_back(mk(0, 0, 1, 1, 11'd0, i == ROW, 1, (i < ROW) ? lw + 11'(i) : 11'd0,
                                   0, 0, i > 0, 0, 0));
            for (int i = 0; i < COL; i++)
                exp_q.push_back(mk(0, 0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 0, 1));
            for (int i = 0; i < DRAIN; i++)
                exp_q.push_back(NOP);
            for (int i = 0; i <= ll; i++)
                exp_q.push_back(mk(0, 0, 1, 1, 11'd0, i == ll, 1, (i < ll) ? la + 11'(i) : 11'd0,
                                   0, 0, i > 0, 0, 0));
            for (int i = 0; i < ll; i++)
                exp_q.push_back(mk(0, 0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 1, 0));
            k = 0; reads = 0; pend = 0; guard = 0;
            while (k < ll && guard < 2000) begin
                j  = exp_q.size();
                v  = (j < obs_v.size()) ? obs_v[j] : 1'b0;
                wr = pend;
                rd = (reads < ll) && v;
                exp_q.push_back(mk(0, 0, !wr, !wr, wr ? lp + 11'(k) : 11'd0, 1, 1, 11'd0,
                                   rd, 0, 0, 0, 0));
                if (wr) k++;
                if (rd) reads++;
                pend = rd;
                guard++;
            end
            if (lacc)
                for (int i = 0; i < ll; i++)
                    exp_q.push_back(mk(lrelu, 1, 0, 1, lp + 11'(i), 1, 1, 11'd0, 0, 0, 0, 0, 0));
        end
        exp_q.push_back(NOP);
    endtask

    task automatic run_tile(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                            input int l, input bit acc, input bit relu, input int vm,
                            input bit restart);
        bit tmo;
        int n;
        obs_q.delete();
        obs_v.delete();
        done_cnt = 0;
        vmode    = vm;
        @(posedge clk); #1;
        w_base = w; a_base = a; p_base = p; len = 11'(l); acc_en = acc; relu_en = relu;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the tile must run on the latched values
        w_base = 11'($urandom); a_base = 11'($urandom); p_base = 11'($urandom);
        len = 11'($urandom_range(1, 9)); acc_en = ~acc; relu_en = ~relu;
        if (restart) begin
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        tmo = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("timeout", {34'd0, tmo}, 35'd0);
        build_exp(w, a, p, l, acc, relu);
        chk("trace_len", 35'(obs_q.size()), 35'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("inst[%0d] len=%0d", i, l), obs_q[i], exp_q[i]);
        chk("done_count", 35'(done_cnt), 35'd1);
        chk("done_latency", 35'(done_cyc - start_cyc), 35'(exp_q.size()));
        @(posedge clk); #1;
        chk("idle_inst", inst, NOP);
    endtask

    initial begin
        bit hit;
        reset = 1'b0; start = 1'b0; acc_en = 1'b0; relu_en = 1'b0;
        w_base = '0; a_base = '0; p_base = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_inst", inst, NOP);
        chk("reset_busy", {34'd0, busy}, 35'd0);
        chk("reset_done", {34'd0, done}, 35'd0);
        reset = 1'b1;

        run_tile(11'd0, 11'd8, 11'd0, 4, 0, 0, 0, 0);          // basic tile
        run_tile(11'd5, 11'd9, 11'd3, 0, 1, 1, 0, 0);          // len = 0 no-op
        run_tile(11'd100, 11'd200, 11'd300, 6, 0, 0, 1, 0);    // ofifo_valid gaps
        run_tile(11'd10, 11'd20, 11'd2046, 4, 1, 1, 2, 0);     // SFP with pmem wrap
        run_tile(11'd2044, 11'd2045, 11'd7, 5, 1, 0, 2, 1);    // restart ignored, xmem wrap

        // Reset while executing
        obs_q.delete(); obs_v.delete(); done_cnt = 0; vmode = 0;
        @(posedge clk); #1;
        w_base = 11'd1; a_base = 11'd2; p_base = 11'd3; len = 11'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (inst[1] === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("exec_reached", {34'd0, hit}, 35'd1);
        reset = 1'b0;
        #1;
        chk("midrst_inst", inst, NOP);
        chk("midrst_busy", {34'd0, busy}, 35'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_done", 35'(done_cnt), 35'd0);
        chk("midrst_idle", inst, NOP);

        for (int r = 0; r < 6; r++)
            run_tile(11'($urandom), 11'($urandom), 11'($urandom), $urandom_range(1, 8),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
